alu_ctrl: RTL and testbench



---
 rtl/alu_ctrl.sv | 173 +++++++++++++++++
 tb/tb_alu_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl.sv
// alu_ctrl: sequencing controller for the 16-bit combinational ALU.
// Accepts one operation per valid/ready request and registers the operands and opcode onto
// the ALU inputs. It holds them for a fixed number of cycles: MULDIV_LAT for MUL/DIV/MOD,
// one cycle for everything else. It then returns the result, a writeback qualifier and the
// flags over a valid/ready response port, and maintains the architectural flag register.
// Optional feature: define ALU_DIV_ZERO_TRAP_EN to trap DIV/MOD with B=0 as an error response.

module alu_ctrl #(
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  // request port
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_opcode,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [2:0]  req_dst,
  // ALU side
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [5:0]  alu_opcode,
  input  logic [15:0] alu_out,
  input  logic        alu_z,
  input  logic        alu_n,
  input  logic        alu_c,
  input  logic        alu_o,
  // response port
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic [2:0]  rsp_dst,
  output logic        rsp_wb,
  output logic        rsp_err,
  output logic [3:0]  flags
);

  localparam logic [5:0] OpFirst = 6'b001010;  // ADD
  localparam logic [5:0] OpMov   = 6'b010000;
  localparam logic [5:0] OpMul   = 6'b010001;
  localparam logic [5:0] OpDiv   = 6'b010010;
  localparam logic [5:0] OpMod   = 6'b010011;
  localparam logic [5:0] OpCmp   = 6'b011000;
  localparam logic [5:0] OpTst   = 6'b011001;
  localparam logic [5:0] OpLast  = 6'b011011;  // DEC

  // Counter reload for the multicycle ops; EXEC lasts HoldLoad+1 cycles.
  localparam logic [3:0] HoldLoad = 4'(MULDIV_LAT - 1);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  op_q;
  logic [15:0] a_q, b_q;
  logic [2:0]  dst_q;
  logic [15:0] rsp_data_q;
  logic [2:0]  rsp_dst_q;
  logic        rsp_wb_q, rsp_err_q;
  logic [3:0]  flags_q;

  logic accept, finish;
  logic req_trap, exe_trap, exe_ok;

  function automatic logic is_legal(input logic [5:0] op);
    return (op >= OpFirst) && (op <= OpLast);
  endfunction

  function automatic logic is_muldiv(input logic [5:0] op);
    return (op == OpMul) || (op == OpDiv) || (op == OpMod);
  endfunction

`ifdef ALU_DIV_ZERO_TRAP_EN
  assign req_trap = ((req_opcode == OpDiv) || (req_opcode == OpMod)) && (req_b == 16'h0000);
  assign exe_trap = ((op_q == OpDiv) || (op_q == OpMod)) && (b_q == 16'h0000);
`else
  assign req_trap = 1'b0;
  assign exe_trap = 1'b0;
`endif

  // A legal, non-trapping op returns the ALU result; everything else is an error response.
  assign exe_ok = is_legal(op_q) && !exe_trap;

  // Next-state, hold counter and capture strobes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = StExec;
          cnt_d   = (is_muldiv(req_opcode) && !req_trap) ? HoldLoad : 4'd0;
        end
      end
      StExec: begin
        if (cnt_q == 4'd0) begin
          finish  = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and hold counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Operand/opcode capture; these drive the ALU and change only on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= 6'b000000;
      a_q   <= 16'h0000;
      b_q   <= 16'h0000;
      dst_q <= 3'd0;
    end else if (accept) begin
      op_q  <= req_opcode;
      a_q   <= req_a;
      b_q   <= req_b;
      dst_q <= req_dst;
    end
  end

  // Response and architectural flag registers, loaded on the EXEC->RESP edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data_q <= 16'h0000;
      rsp_dst_q  <= 3'd0;
      rsp_wb_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
      flags_q    <= 4'b0000;
    end else if (finish) begin
      rsp_data_q <= exe_ok ? alu_out : 16'h0000;
      rsp_dst_q  <= dst_q;
      rsp_err_q  <= !exe_ok;
      // CMP/TST only set flags; they have no register result
      rsp_wb_q   <= exe_ok && (op_q != OpCmp) && (op_q != OpTst);
      if (exe_ok && (op_q != OpMov)) begin
        flags_q <= {alu_z, alu_n, alu_c, alu_o};
      end
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign rsp_valid  = (state_q == StResp);
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_opcode = op_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_dst    = rsp_dst_q;
  assign rsp_wb     = rsp_wb_q;
  assign rsp_err    = rsp_err_q;
  assign flags      = flags_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: directed bench for alu_ctrl with a stand-in ALU and a response scoreboard.
// The stand-in ALU returns a poison value for MUL/DIV/MOD until its inputs have been stable
// for MULDIV_LAT cycles, so an early sample shows up as a wrong result.
// Honours ALU_DIV_ZERO_TRAP_EN in the same way as the design.

module tb_alu_ctrl;

  localparam int unsigned LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_opcode = 6'd0;
  logic [15:0] req_a = 16'h0, req_b = 16'h0;
  logic [2:0]  req_dst = 3'd0;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [5:0]  alu_opcode;
  logic        alu_z, alu_n, alu_c, alu_o;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_dst;
  logic        rsp_wb, rsp_err;
  logic [3:0]  flags;

  alu_ctrl #(.MULDIV_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b), .req_dst(req_dst),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_out(alu_out),
    .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_o(alu_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_dst(rsp_dst),
    .rsp_wb(rsp_wb), .rsp_err(rsp_err), .flags(flags)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: returns {result, Z, N, C, O}. ADD reports unsigned overflow in O.
  function automatic logic [19:0] alu_model(input logic [5:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic        c, o;
    r = 16'h0; c = 1'b0; o = 1'b0; s = 17'h0;
    case (op)
      6'd10: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16]; o = s[16]; end
      6'd11, 6'd24: begin
        r = a - b; c = (a >= b); o = (a[15] != b[15]) && (r[15] != a[15]);
      end
      6'd12: r = a >> b[3:0];
      6'd13: r = a << b[3:0];
      6'd14: r = (a >> b[3:0]) | (a << (16 - b[3:0]));
      6'd15: r = (a << b[3:0]) | (a >> (16 - b[3:0]));
      6'd16: r = b;
      6'd17: r = a * b;
      6'd18: r = (b == 16'h0) ? 16'hFFFF : a / b;
      6'd19: r = (b == 16'h0) ? a : a % b;
      6'd20: r = a & b;
      6'd21: r = a | b;
      6'd22: r = a ^ b;
      6'd23: r = ~a;
      6'd25: r = a & b;
      6'd26: begin s = {1'b0, a} + 17'd1; r = s[15:0]; c = s[16]; end
      6'd27: r = a - 16'd1;
      default: r = 16'h0;
    endcase
    return {r, (r == 16'h0), r[15], c, o};
  endfunction

  function automatic logic is_muldiv(input logic [5:0] op);
    return (op == 6'd17) || (op == 6'd18) || (op == 6'd19);
  endfunction

  // Input-stability counter for the stand-in ALU's multicycle path
  int          stab = 0;
  logic [37:0] prev_in = '0;
  always @(negedge clk) begin
    if ({alu_opcode, alu_a, alu_b} != prev_in) stab <= 0;
    else if (stab < 100) stab <= stab + 1;
    prev_in <= {alu_opcode, alu_a, alu_b};
  end

  logic [19:0] alu_res;
  logic        unsettled;
  assign alu_res   = alu_model(alu_opcode, alu_a, alu_b);
  assign unsettled = is_muldiv(alu_opcode) && (stab < int'(LAT) - 1);
  assign alu_out   = unsettled ? 16'hDEAD : alu_res[19:4];
  assign {alu_z, alu_n, alu_c, alu_o} = unsettled ? 4'b0101 : alu_res[3:0];

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  dst;
    logic        wb;
    logic        err;
    logic [3:0]  flg;
  } rsp_t;

  rsp_t        sb[$];
  logic [3:0]  mdl_flags = 4'b0000;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] last_data;
  logic        last_wb, last_err;
  logic [3:0]  last_flags;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected response from opcode/operands plus the controller's err/wb/flags rules
  function automatic rsp_t predict(input logic [5:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input logic [2:0] dst,
                                   input logic [3:0] cur_flags);
    rsp_t        e;
    logic [19:0] m;
    logic        legal, trap;
    legal = (op >= 6'd10) && (op <= 6'd27);
`ifdef ALU_DIV_ZERO_TRAP_EN
    trap = ((op == 6'd18) || (op == 6'd19)) && (b == 16'h0);
`else
    trap = 1'b0;
`endif
    m = alu_model(op, a, b);
    e.dst = dst;
    if (!legal || trap) begin
      e.data = 16'h0; e.wb = 1'b0; e.err = 1'b1; e.flg = cur_flags;
    end else begin
      e.data = m[19:4];
      e.wb   = !((op == 6'd24) || (op == 6'd25));
      e.err  = 1'b0;
      e.flg  = (op == 6'd16) ? cur_flags : m[3:0];
    end
    return e;
  endfunction

  // One complete transaction; rsp_ready held low for 'stall' RESP cycles
  task automatic run_op(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] dst, input int stall, input int exp_lat);
    rsp_t e;
    int   lat;
    e = predict(op, a, b, dst, mdl_flags);
    sb.push_back(e);
    mdl_flags = e.flg;
    @(negedge clk);
    check("req_ready_idle", {31'b0, req_ready}, 1);
    req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b; req_dst = dst;
    rsp_ready = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    // Keep offering junk while busy; it must be ignored
    req_opcode = 6'($urandom); req_a = 16'($urandom); req_b = 16'($urandom);
    req_dst = 3'($urandom);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      check("busy_req_ready", {31'b0, req_ready}, 0);
      check("hold_alu_a", {16'b0, alu_a}, {16'b0, a});
      check("hold_alu_b", {16'b0, alu_b}, {16'b0, b});
      check("hold_alu_op", {26'b0, alu_opcode}, {26'b0, op});
      @(negedge clk);
      lat++;
    end
    check("latency", lat, exp_lat);
    for (int i = 0; i < stall; i++) begin
      check("stall_valid", {31'b0, rsp_valid}, 1);
      check("stall_data", {16'b0, rsp_data}, {16'b0, e.data});
      check("stall_err", {31'b0, rsp_err}, {31'b0, e.err});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    if (sb.size() == 0) begin
      check("sb_nonempty", 0, 1);
    end else begin
      e = sb.pop_front();
      check("rsp_valid", {31'b0, rsp_valid}, 1);
      check("rsp_data", {16'b0, rsp_data}, {16'b0, e.data});
      check("rsp_dst", {29'b0, rsp_dst}, {29'b0, e.dst});
      check("rsp_wb", {31'b0, rsp_wb}, {31'b0, e.wb});
      check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
      check("flags", {28'b0, flags}, {28'b0, e.flg});
    end
    last_data = rsp_data; last_wb = rsp_wb; last_err = rsp_err; last_flags = flags;
    @(negedge clk);
    check("back_idle_ready", {31'b0, req_ready}, 1);
    check("back_idle_valid", {31'b0, rsp_valid}, 0);
    check("no_capture_busy", {16'b0, alu_a}, {16'b0, a});
    req_valid = 1'b0;
    rsp_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_req_ready", {31'b0, req_ready}, 1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    check("rst_rsp_wb_err", {30'b0, rsp_wb, rsp_err}, 0);
    check("rst_rsp_data", {13'b0, rsp_dst, rsp_data}, 0);
    check("rst_alu", {alu_a, alu_b}, 0);
    check("rst_alu_op_flags", {22'b0, alu_opcode, flags}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // ADD FFFF+0001
    run_op(6'd10, 16'hFFFF, 16'h0001, 3'd1, 0, 2);
    check("add_data", {16'b0, last_data}, 32'h0000);
    check("add_wb", {31'b0, last_wb}, 1);
    check("add_flags", {28'b0, last_flags}, 32'b1011);

    // MUL 2*4, multicycle
    run_op(6'd17, 16'h0002, 16'h0004, 3'd2, 0, int'(LAT) + 1);
    check("mul_data", {16'b0, last_data}, 32'h0008);

    // CMP then MOV
    run_op(6'd24, 16'hFFFE, 16'h0001, 3'd3, 0, 2);
    check("cmp_wb", {31'b0, last_wb}, 0);
    check("cmp_flags", {28'b0, last_flags}, 32'b0110);
    run_op(6'd16, 16'h1234, 16'h4321, 3'd4, 0, 2);
    check("mov_data", {16'b0, last_data}, 32'h4321);
    check("mov_wb", {31'b0, last_wb}, 1);
    check("mov_flags", {28'b0, last_flags}, 32'b0110);

    // Illegal opcode then SUB
    run_op(6'b111111, 16'h5555, 16'h3333, 3'd5, 0, 2);
    check("ill_err", {31'b0, last_err}, 1);
    check("ill_wb", {31'b0, last_wb}, 0);
    check("ill_flags", {28'b0, last_flags}, 32'b0110);
    run_op(6'd11, 16'hFFFE, 16'h0001, 3'd6, 0, 2);
    check("sub_data", {16'b0, last_data}, 32'hFFFD);
    run_op(6'b001001, 16'h0001, 16'h0001, 3'd0, 0, 2);   // just below legal range
    run_op(6'b011100, 16'h0001, 16'h0001, 3'd0, 0, 2);   // just above legal range

    // DIV by zero with a 5-cycle response stall
`ifdef ALU_DIV_ZERO_TRAP_EN
    run_op(6'd18, 16'h000A, 16'h0000, 3'd7, 5, 2);
    check("div0_err", {31'b0, last_err}, 1);
`else
    run_op(6'd18, 16'h000A, 16'h0000, 3'd7, 5, int'(LAT) + 1);
    check("div0_err", {31'b0, last_err}, 0);
    check("div0_wb", {31'b0, last_wb}, 1);
`endif

    // Assorted ops, including a stall on a multicycle result
    run_op(6'd18, 16'h0064, 16'h0007, 3'd1, 2, int'(LAT) + 1);
    run_op(6'd19, 16'h0064, 16'h0007, 3'd2, 0, int'(LAT) + 1);
    run_op(6'd13, 16'h8001, 16'h0001, 3'd3, 0, 2);
    run_op(6'd14, 16'h00F1, 16'h0004, 3'd4, 1, 2);
    run_op(6'd23, 16'h00FF, 16'h0000, 3'd5, 0, 2);
    run_op(6'd25, 16'hF0F0, 16'h0F0F, 3'd6, 0, 2);
    run_op(6'd26, 16'hFFFF, 16'h0000, 3'd7, 0, 2);
    run_op(6'd27, 16'h0001, 16'h0000, 3'd0, 0, 2);
    run_op(6'd11, 16'h0001, 16'h0002, 3'd1, 0, 2);   // leave flags non-zero before reset test

    // Reset pulsed two cycles into a MOD
    @(negedge clk);
    req_valid = 1'b1; req_opcode = 6'd19; req_a = 16'h0031; req_b = 16'h0005; req_dst = 3'd2;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_req_ready", {31'b0, req_ready}, 1);
    check("abort_rsp_valid", {31'b0, rsp_valid}, 0);
    check("abort_flags", {28'b0, flags}, 0);
    mdl_flags = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      check("abort_no_rsp", {31'b0, rsp_valid}, 0);
    end
    run_op(6'd20, 16'hAAAA, 16'hAA22, 3'd3, 0, 2);
    check("and_data", {16'b0, last_data}, 32'hAA22);
    check("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
